winograd_tile_gen: RTL and testbench
====================================

WINOGRAD_TILE_GEN -- requirements
Module: winograd_tile_gen

Interface
REQ-001 Parameter IMG_W, default 8, feature-map width in pixels; SHALL be even and >= 4.
REQ-002 Parameter IMG_H, default 8, feature-map height in pixels; SHALL be even and >= 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pix_in  input  8  raster-order (row-major) feature-map pixel.
REQ-006 pix_valid  input  1  pix_in is valid.
REQ-007 pix_ready  output  1  block accepts pix_in this cycle.
REQ-008 tile_data  output  128  4x4 input tile; byte 4*r+c (bits 8*(4*r+c)+7 : 8*(4*r+c)) = pixel (band_row+r, tile_col+c).
REQ-009 tile_valid  output  1  tile_data is valid.
REQ-010 tile_ready  input  1  downstream Winograd engine accepts tile.
REQ-011 frame_done  output  1  one-cycle pulse after last tile of frame is accepted.

Function
REQ-012 Block SHALL emit overlapping 4x4 tiles at stride 2 in both axes, for F(2x2,3x3) valid convolution: (IMG_W-2)/2 tiles per band, (IMG_H-2)/2 bands, band-major then column order.
REQ-013 Storage SHALL be a 4-row circular line buffer (4*IMG_W bytes) with a 2-bit oldest-row pointer.
REQ-014 FSM states SHALL be FILL, EMIT, DONE.
REQ-015 FILL: pix_ready=1, tile_valid=0; pixel accepted when pix_valid && pix_ready; first band requires 4*IMG_W pixels, each later band requires 2*IMG_W new pixels overwriting the two oldest rows.
REQ-016 FILL->EMIT on the clock edge accepting the last pixel of the required rows; tile_valid SHALL be 1 in the next cycle (1-cycle latency).
REQ-017 EMIT: pix_ready=0; tile_valid=1; tile_data and tile_valid SHALL hold stable while tile_ready=0.
REQ-018 EMIT: each handshake (tile_valid && tile_ready) advances tile_col by 2; throughput one tile per cycle with tile_ready held high.
REQ-019 After last tile of a band is accepted: if more bands remain, advance oldest-row pointer by 2 (mod 4), band_row += 2, go to FILL; otherwise go to DONE.
REQ-020 DONE lasts exactly one cycle with frame_done=1, pix_ready=0, tile_valid=0, then FILL for next frame with all counters and pointer cleared.
REQ-021 Pixels presented while pix_ready=0 SHALL NOT be consumed; no pixel SHALL be dropped or duplicated.
REQ-022 Row/column counters SHALL wrap at IMG_W/IMG_H exactly; no out-of-range buffer index.

Reset
REQ-023 rst asserted at any time, including mid-fill or mid-emit, SHALL immediately force FILL, clear counters and pointer, pix_ready=1 after deassertion, tile_valid=0, frame_done=0, tile_data=0.
REQ-024 Line-buffer contents need not be cleared; they SHALL never be emitted before being rewritten.

Configuration
REQ-025 Macro WINO_TILE_COORD_EN: when defined, adds outputs tile_row_idx and tile_col_idx (each $clog2(IMG_H) / $clog2(IMG_W) bits, reset 0) giving the tile origin, valid with tile_valid; when undefined, those ports do not exist and behaviour is otherwise identical.

Structure
REQ-026 Package winograd_pkg SHALL hold WINO_TILE=4, WINO_OUT=2, WINO_STRIDE=2, WINO_DW=8, the 128-bit tile typedef and FSM state enum.
REQ-027 Sub-module wino_line_buf SHALL implement the 4-row circular storage (one write port, 16-byte tile read port addressed by column and oldest-row pointer).

Verification
REQ-028 8x8 frame, pixel = 8*row+col, tile_ready=1 -> 9 tiles; tile 0 byte0=0, byte15=27; first tile_valid one cycle after 32nd pixel accepted.
REQ-029 Same frame -> tile (band1,col1) byte0=18, byte15=45; last tile byte0=36, byte15=63; frame_done pulses once, one cycle after 9th accept.
REQ-030 tile_ready low 5 cycles on tile 4 -> tile_valid stays 1, tile_data unchanged, pix_ready stays 0.
REQ-031 pix_valid toggled randomly 50% -> same 9 tiles, identical bytes, pix_ready=0 throughout every EMIT.
REQ-032 rst pulsed after 20 pixels -> outputs at reset values; fresh 8x8 frame then yields tile 0 byte0=0, byte15=27.
REQ-033 Two back-to-back frames -> 18 tiles, two frame_done pulses, second frame tiles match first-frame golden values.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared constants, tile type and FSM state encoding for the Winograd F(2x2,3x3) tile generator.
package winograd_pkg;

    localparam int WINO_TILE      = 4;
    localparam int WINO_OUT       = 2;
    localparam int WINO_STRIDE    = 2;
    localparam int WINO_DW        = 8;
    localparam int WINO_TILE_BITS = WINO_TILE * WINO_TILE * WINO_DW;

    typedef logic [WINO_TILE_BITS-1:0] wino_tile_t;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } wino_state_e;

    // LSB position of tile byte (r, c) inside a packed tile word.
    function automatic int tile_byte_lsb(input int r, input int c);
        return WINO_DW * (WINO_TILE * r + c);
    endfunction

endpackage

// File: rtl/wino_line_buf.sv
// Four-row circular line buffer: one pixel write port and a 4x4 tile read port
// addressed by oldest-row pointer and column, with write-through forwarding.
module wino_line_buf
    import winograd_pkg::*;
#(
    parameter int IMG_W = 8,
    localparam int CW = $clog2(IMG_W)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [1:0]         wr_row,
    input  logic [CW-1:0]      wr_col,
    input  logic [WINO_DW-1:0] wr_data,
    input  logic [1:0]         rd_ptr,
    input  logic [CW-1:0]      rd_col,
    output wino_tile_t         rd_tile
);

    logic [WINO_DW-1:0] mem_q [WINO_TILE][IMG_W];

    // Row storage; contents are never read before the fill sequence rewrites them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_row][wr_col] <= wr_data;
        end
    end

    // Tile gather; a pixel written this cycle is forwarded so the first tile of a band is complete.
    always_comb begin
        logic [1:0]    row_idx;
        logic [CW-1:0] col_idx;
        row_idx = 2'd0;
        col_idx = '0;
        rd_tile = '0;
        for (int r = 0; r < WINO_TILE; r++) begin
            for (int c = 0; c < WINO_TILE; c++) begin
                row_idx = rd_ptr + 2'(r);
                col_idx = rd_col + CW'(c);
                if (wr_en && (wr_row == row_idx) && (wr_col == col_idx)) begin
                    rd_tile[tile_byte_lsb(r, c) +: WINO_DW] = wr_data;
                end else begin
                    rd_tile[tile_byte_lsb(r, c) +: WINO_DW] = mem_q[row_idx][col_idx];
                end
            end
        end
    end

endmodule

// File: rtl/winograd_tile_gen.sv
// Raster-pixel to overlapping 4x4 (stride 2) tile generator for F(2x2,3x3) Winograd convolution.
// Optional macro WINO_TILE_COORD_EN adds tile_row_idx / tile_col_idx origin outputs.
module winograd_tile_gen
    import winograd_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WINO_DW-1:0]        pix_in,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic [WINO_TILE_BITS-1:0] tile_data,
    output logic                      tile_valid,
    input  logic                      tile_ready,
    output logic                      frame_done
`ifdef WINO_TILE_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0]  tile_row_idx,
    output logic [$clog2(IMG_W)-1:0]  tile_col_idx
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] TILE_COL_LAST = CW'(IMG_W - WINO_TILE);
    localparam logic [RW-1:0] BAND_LAST     = RW'(IMG_H - WINO_TILE);

    wino_state_e   state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    fill_row_q, fill_row_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [RW-1:0] band_q, band_d;
    logic [CW-1:0] tile_col_q, tile_col_d;
    logic          pix_ready_q, pix_ready_d;
    logic          tile_valid_q, tile_valid_d;
    logic          frame_done_q, frame_done_d;
    wino_tile_t    tile_data_q, tile_data_d;
    wino_tile_t    rd_tile;
    logic          pix_acc;

    wino_line_buf #(.IMG_W(IMG_W)) u_line_buf (
        .clk     (clk),
        .wr_en   (pix_acc),
        .wr_row  (ptr_q + fill_row_q),
        .wr_col  (col_q),
        .wr_data (pix_in),
        .rd_ptr  (ptr_d),
        .rd_col  (tile_col_d),
        .rd_tile (rd_tile)
    );

    // Next-state, fill/emit counters and pointer management.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        fill_row_d = fill_row_q;
        ptr_d      = ptr_q;
        band_d     = band_q;
        tile_col_d = tile_col_q;
        pix_acc    = 1'b0;
        case (state_q)
            ST_FILL: begin
                pix_acc = pix_valid & pix_ready_q;
                if (pix_acc) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (fill_row_q == 2'd3) begin
                            // Later bands only refill the two rows that fell out of the window.
                            state_d    = ST_EMIT;
                            fill_row_d = 2'd2;
                        end else begin
                            fill_row_d = fill_row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_EMIT: begin
                if (tile_ready) begin
                    if (tile_col_q == TILE_COL_LAST) begin
                        tile_col_d = '0;
                        if (band_q == BAND_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FILL;
                            band_d  = band_q + RW'(WINO_STRIDE);
                            ptr_d   = ptr_q + 2'(WINO_STRIDE);
                        end
                    end else begin
                        tile_col_d = tile_col_q + CW'(WINO_STRIDE);
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d    = ST_FILL;
                col_d      = '0;
                fill_row_d = 2'd0;
                ptr_d      = 2'd0;
                band_d     = '0;
                tile_col_d = '0;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Registered-output decode from the next state.
    always_comb begin
        pix_ready_d  = (state_d == ST_FILL);
        tile_valid_d = (state_d == ST_EMIT);
        frame_done_d = (state_d == ST_DONE);
        if (state_d == ST_EMIT) begin
            tile_data_d = rd_tile;
        end else begin
            tile_data_d = tile_data_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FILL;
            col_q        <= '0;
            fill_row_q   <= 2'd0;
            ptr_q        <= 2'd0;
            band_q       <= '0;
            tile_col_q   <= '0;
            pix_ready_q  <= 1'b1;
            tile_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            tile_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            fill_row_q   <= fill_row_d;
            ptr_q        <= ptr_d;
            band_q       <= band_d;
            tile_col_q   <= tile_col_d;
            pix_ready_q  <= pix_ready_d;
            tile_valid_q <= tile_valid_d;
            frame_done_q <= frame_done_d;
            tile_data_q  <= tile_data_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign tile_valid = tile_valid_q;
    assign frame_done = frame_done_q;
    assign tile_data  = tile_data_q;
`ifdef WINO_TILE_COORD_EN
    assign tile_row_idx = band_q;
    assign tile_col_idx = tile_col_q;
`endif

endmodule

// File: tb/tb_winograd_tile_gen.sv
// Self-checking bench for winograd_tile_gen: frame-level tile model plus hand-computed golden bytes.
module tb_winograd_tile_gen;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int TW = (W - 2) / 2;
    localparam int NT = TW * ((H - 2) / 2);
    localparam int NP = W * H;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [127:0] tile_data;
    logic         tile_valid;
    logic         tile_ready;
    logic         frame_done;
`ifdef WINO_TILE_COORD_EN
    logic [2:0]   tile_row_idx;
    logic [2:0]   tile_col_idx;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   pix_q[$];
    logic [7:0]   frame_pix[NP];
    logic [127:0] tile_log[NT];
    int n_acc = 0, n_tiles = 0, done_cnt = 0, total_tiles = 0, pct = 100;
    bit valid_due = 1'b0, done_due = 1'b0, stall_req = 1'b0, stall_seen = 1'b0;

    winograd_tile_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .tile_data  (tile_data),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .frame_done (frame_done)
`ifdef WINO_TILE_COORD_EN
        ,
        .tile_row_idx (tile_row_idx),
        .tile_col_idx (tile_col_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel source: presents the queue head, pops it once the handshake edge has passed.
    initial begin
        bit acc;
        pix_valid = 1'b0;
        pix_in    = 8'd0;
        forever begin
            @(negedge clk);
            acc = pix_valid && pix_ready && !rst;
            @(posedge clk);
            #1;
            if (acc && pix_q.size() > 0) void'(pix_q.pop_front());
            if (pix_q.size() > 0 && $urandom_range(99) < pct) begin
                pix_valid = 1'b1;
                pix_in    = pix_q[0];
            end else begin
                pix_valid = 1'b0;
                pix_in    = 8'($urandom);
            end
        end
    end

    // Tile sink: ready high, except an optional 5-cycle stall on tile 4 with hold checks.
    initial begin
        logic [127:0] hold;
        tile_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && tile_valid && n_tiles == 4) begin
                hold       = tile_data;
                tile_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_valid", tile_valid, 1);
                    chk("stall_data", tile_data, hold);
                    chk("stall_pix_ready", pix_ready, 0);
                    @(posedge clk);
                    #1;
                end
                tile_ready = 1'b1;
                stall_req  = 1'b0;
                stall_seen = 1'b1;
            end
        end
    end

    // Compare process: frame model built from accepted pixels, checked every cycle.
    always @(negedge clk) begin
        logic [127:0] exp_t;
        int b, c, idx;
        bit early;
        if (rst) begin
            n_acc = 0; n_tiles = 0; valid_due = 1'b0; done_due = 1'b0;
        end else begin
            if (valid_due) chk("band_first_valid", tile_valid, 1);
            if (done_due) begin
                chk("frame_done_pulse", frame_done, 1);
                done_cnt++;
                n_acc   = 0;
                n_tiles = 0;
            end else if (frame_done) begin
                chk("frame_done_spurious", frame_done, 0);
            end
            valid_due = 1'b0;
            done_due  = 1'b0;
            if (tile_valid) chk("pix_ready_in_emit", pix_ready, 0);
            if (tile_valid && tile_ready) begin
                b = n_tiles / TW;
                c = n_tiles % TW;
                early = 1'b0;
                exp_t = '0;
                for (int r = 0; r < 4; r++) begin
                    for (int cc = 0; cc < 4; cc++) begin
                        idx = (2 * b + r) * W + 2 * c + cc;
                        if (idx >= n_acc) early = 1'b1;
                        else exp_t[8 * (4 * r + cc) +: 8] = frame_pix[idx];
                    end
                end
                chk("tile_before_pixels", early, 0);
                chk($sformatf("tile_%0d_data", n_tiles), tile_data, exp_t);
`ifdef WINO_TILE_COORD_EN
                chk("tile_row_idx", tile_row_idx, 2 * b);
                chk("tile_col_idx", tile_col_idx, 2 * c);
`endif
                if (n_tiles < NT) tile_log[n_tiles] = tile_data;
                n_tiles++;
                total_tiles++;
                if (n_tiles == NT) done_due = 1'b1;
            end
            if (pix_valid && pix_ready) begin
                if (n_acc < NP) frame_pix[n_acc] = pix_in;
                n_acc++;
                if (n_acc >= 4 * W && (n_acc - 4 * W) % (2 * W) == 0) valid_due = 1'b1;
            end
        end
    end

    task automatic push_frame();
        for (int i = 0; i < NP; i++) pix_q.push_back(8'(i));
    endtask

    task automatic wait_done(input int target, input int budget);
        int cyc = 0;
        while (done_cnt < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame_done_count", done_cnt, target);
    endtask

    task automatic check_golden(input string tag);
        chk({tag, "_t0_b0"},  tile_log[0][7:0],     0);
        chk({tag, "_t0_b15"}, tile_log[0][127:120], 27);
        chk({tag, "_t4_b0"},  tile_log[4][7:0],     18);
        chk({tag, "_t4_b15"}, tile_log[4][127:120], 45);
        chk({tag, "_t8_b0"},  tile_log[8][7:0],     36);
        chk({tag, "_t8_b15"}, tile_log[8][127:120], 63);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pix_ready"},  pix_ready,  1);
        chk({tag, "_tile_valid"}, tile_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_tile_data"},  tile_data,  0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        push_frame();
        wait_done(1, 3000);
        check_golden("basic");

        stall_req = 1'b1;
        push_frame();
        wait_done(2, 3000);
        check_golden("stall");
        chk("stall_happened", stall_seen, 1);

        pct = 50;
        push_frame();
        wait_done(3, 6000);
        check_golden("rand50");
        pct = 100;

        push_frame();
        cyc = 0;
        while (n_acc < 20 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_20_pixels", (n_acc >= 20), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        pix_q.delete();
        @(negedge clk);
        check_reset_outputs("midfill");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_frame();
        wait_done(4, 3000);
        check_golden("after_rst");

        push_frame();
        push_frame();
        wait_done(6, 6000);
        check_golden("b2b");
        repeat (20) @(negedge clk);
        chk("final_done_count", done_cnt, 6);
        chk("total_tiles", total_tiles, 6 * NT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
